// File: rtl/shifter_pkg.sv
// ============================================================================
// Package     : shifter_pkg
// Description : Shared types and helpers for the iterative shift unit.
//               - shift_state_t : control FSM states
//               - stage_count() : number of compute cycles for a given width
//               - shift_req_t   : request bundle for the default 32-bit build
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } shift_state_t;

  // One compute cycle per shamt bit.
  function automatic int stage_count(input int xlen);
    return $clog2(xlen);
  endfunction

  localparam int DEFAULT_XLEN   = 32;
  localparam int DEFAULT_STAGES = stage_count(DEFAULT_XLEN);

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0]   data;
    logic [DEFAULT_STAGES-1:0] shamt;
    logic                      left_or_right;
    logic                      arithmetic;
  } shift_req_t;

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
// ============================================================================
// Module      : shift_stage
// Description : Combinational shift of i_data by 2^i_k. The STAGES
//               fixed-distance shifts are built side by side and i_k selects
//               one of them, so only one shifter row is shared by all cycles.
// Ports       : i_data  - operand
//               i_k     - stage index (distance = 2^i_k)
//               i_right - 0 = left (zero fill), 1 = right (fill with i_fill)
//               i_fill  - bit shifted in on right shifts
//               o_data  - shifted operand
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_stage
  import shifter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = stage_count(XLEN),
  parameter int K_W    = $clog2(STAGES)
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [K_W-1:0]  i_k,
  input  logic            i_right,
  input  logic            i_fill,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_dist [STAGES];

  for (genvar j = 0; j < STAGES; j++) begin : g_dist
    localparam int D = 1 << j;
    assign w_dist[j] = i_right ? {{D{i_fill}}, i_data[XLEN-1:D]}
                               : {i_data[XLEN-1-D:0], {D{1'b0}}};
  end

  // Index values past STAGES-1 are unreachable; they pass data through.
  always_comb begin
    o_data = i_data;
    for (int j = 0; j < STAGES; j++) begin
      if (i_k == K_W'(j)) o_data = w_dist[j];
    end
  end

endmodule

`default_nettype wire

// File: rtl/iterative_shift_unit.sv
// ============================================================================
// Module      : iterative_shift_unit
// Description : Multi-cycle SLL/SRL/SRA unit. Resolves one shamt bit per
//               cycle (LSB first) through a single shift-by-2^k datapath,
//               giving a fixed latency of $clog2(XLEN) cycles.
// Ports       : clock, reset_n       - clock, async active-low reset
//               flush                - synchronous abort of in-flight work
//               req_valid/req_ready  - request handshake
//               req_data, req_shamt  - operand and shift amount
//               req_left_or_right    - 0 = left, 1 = right
//               req_arithmetic       - sign fill on right shifts
//               rsp_valid/rsp_ready  - response handshake
//               rsp_data             - result (zero unless rsp_valid)
//               busy                 - high while BUSY or DONE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_shift_unit
  import shifter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_data,
  input  logic [$clog2(XLEN)-1:0]  req_shamt,
  input  logic                     req_left_or_right,
  input  logic                     req_arithmetic,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_data,
  output logic                     busy
);

  localparam int STAGES = stage_count(XLEN);
  localparam int K_W    = $clog2(STAGES);
  localparam logic [K_W-1:0] c_last_k = K_W'(STAGES - 1);

  shift_state_t    r_state;
  shift_state_t    w_next_state;
  logic [K_W-1:0]  r_k;
  logic [XLEN-1:0] r_work;
  logic [STAGES-1:0] r_shamt;
  logic            r_right;
  logic            r_fill;
  logic            w_accept;
  logic [XLEN-1:0] w_stage_out;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        // Flush wins over a simultaneous request: nothing is captured.
        if (req_valid && !flush) begin
          w_accept     = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (r_k == c_last_k) w_next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (flush) w_next_state = IDLE;
  end

  // Only the finished value is ever visible on the response bus.
  assign rsp_data = rsp_valid ? r_work : '0;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  shift_stage #(
    .XLEN   (XLEN),
    .STAGES (STAGES),
    .K_W    (K_W)
  ) u_shift_stage (
    .i_data  (r_work),
    .i_k     (r_k),
    .i_right (r_right),
    .i_fill  (r_fill),
    .o_data  (w_stage_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_work  <= '0;
      r_shamt <= '0;
      r_right <= 1'b0;
      r_fill  <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_work  <= req_data;
      r_shamt <= req_shamt;
      r_right <= req_left_or_right;
      // Sign of the original operand, held for every stage of the operation.
      r_fill  <= req_arithmetic & req_left_or_right & req_data[XLEN-1];
      r_k     <= '0;
    end else if (r_state == BUSY && !flush) begin
      if (r_shamt[r_k]) r_work <= w_stage_out;
      r_k <= r_k + K_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
// ============================================================================
// Module      : tb_iterative_shift_unit
// Description : Self-checking bench for iterative_shift_unit (XLEN=32).
//               A negedge monitor pushes the reference result when a request
//               is accepted and compares it when the response handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_shift_unit;
  import shifter_pkg::*;

  localparam int XLEN = 32;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_data;
  logic [4:0]        req_shamt;
  logic              req_left_or_right;
  logic              req_arithmetic;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic              busy;

  always #5 clock = ~clock;

  iterative_shift_unit #(.XLEN(XLEN)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .flush             (flush),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_data          (req_data),
    .req_shamt         (req_shamt),
    .req_left_or_right (req_left_or_right),
    .req_arithmetic    (req_arithmetic),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .busy              (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q [$];
  shift_req_t  mon_req;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input shift_req_t r);
    if (!r.left_or_right)  return r.data << r.shamt;
    else if (r.arithmetic) return $signed(r.data) >>> r.shamt;
    else                   return r.data >> r.shamt;
  endfunction

  // Scoreboard: push on accepting edge, pop on response handshake edge.
  always @(negedge clock) begin
    if (!reset_n || flush) begin
      sb_q.delete();
    end else begin
      if (req_valid && req_ready) begin
        mon_req.data          = req_data;
        mon_req.shamt         = req_shamt;
        mon_req.left_or_right = req_left_or_right;
        mon_req.arithmetic    = req_arithmetic;
        sb_q.push_back(ref_shift(mon_req));
      end
      if (rsp_valid && rsp_ready) begin
        check_eq("sb_pending", sb_q.size(), 1);
        if (sb_q.size() > 0) check_eq("rsp_data", rsp_data, sb_q.pop_front());
      end
    end
  end

  // Present a request for one cycle starting in IDLE; scramble the request
  // inputs afterwards so any late sampling shows up in the result.
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic r, input logic a);
    @(posedge clock); #1;
    req_valid = 1'b1; req_data = d; req_shamt = s;
    req_left_or_right = r; req_arithmetic = a;
    @(posedge clock); #1;
    req_valid         = 1'b0;
    req_data          = $urandom;
    req_shamt         = 5'($urandom);
    req_left_or_right = 1'($urandom);
    req_arithmetic    = 1'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int lat = 0;
    while (!rsp_valid && lat < 20) begin
      check_eq({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
      @(posedge clock); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 5);
  endtask

  task automatic complete(input string tag);
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic r, input logic a, input logic [31:0] exp);
    issue(d, s, r, a);
    wait_valid(tag);
    check_eq({tag, "_result"}, rsp_data, exp);
    complete(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, "_rsp_data"}, rsp_data, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic seen;
    int   cyc;
    reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_data = '0; req_shamt = '0;
    req_left_or_right = 1'b0; req_arithmetic = 1'b0; rsp_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check_reset_outputs("post_reset");

    // SLL 1 by 31 with response backpressure.
    issue(32'h0000_0001, 5'd31, 1'b0, 1'b0);
    wait_valid("sll31");
    repeat (3) begin
      check_eq("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("hold_data", rsp_data, 32'h8000_0000);
      check_eq("ready_in_done", {31'd0, req_ready}, 32'd0);
      @(posedge clock); #1;
    end
    complete("sll31");

    run_op("sra4",  32'h8000_00F0, 5'd4,  1'b1, 1'b1, 32'hF800_000F);
    run_op("srl4",  32'h8000_00F0, 5'd4,  1'b1, 1'b0, 32'h0800_000F);
    run_op("sra31", 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run_op("sll0",  32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 32'hDEAD_BEEF);
    run_op("sll8a", 32'hDEAD_BEEF, 5'd8,  1'b0, 1'b1, 32'hADBE_EF00);
    run_op("sll31b", 32'h7FFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h8000_0000);
    run_op("sra_pos", 32'h7000_0000, 5'd3, 1'b1, 1'b1, 32'h0E00_0000);

    // Flush during BUSY.
    issue(32'h1234_5678, 5'd5, 1'b1, 1'b0);
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check_eq("flush_busy_idle", {31'd0, busy}, 32'd0);
    check_eq("flush_busy_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (8) begin @(posedge clock); #1; seen |= rsp_valid; end
    check_eq("flush_busy_no_rsp", {31'd0, seen}, 32'd0);

    // Flush together with a request in IDLE.
    @(posedge clock); #1;
    req_valid = 1'b1; flush = 1'b1; req_data = 32'hCAFE_F00D; req_shamt = 5'd1;
    @(posedge clock); #1;
    req_valid = 1'b0; flush = 1'b0;
    check_eq("flush_idle_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (7) begin @(posedge clock); #1; seen |= rsp_valid; end
    check_eq("flush_idle_no_rsp", {31'd0, seen}, 32'd0);

    // Flush in DONE while the consumer is ready.
    issue(32'h0000_00FF, 5'd4, 1'b0, 1'b0);
    wait_valid("pre_flush");
    flush = 1'b1; rsp_ready = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; rsp_ready = 1'b0;
    check_eq("flush_done_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("flush_done_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-BUSY and in DONE.
    issue(32'hF0F0_F0F0, 5'd7, 1'b1, 1'b1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1 check_reset_outputs("rst_busy");
    @(posedge clock); #1 reset_n = 1'b1;
    issue(32'hF0F0_F0F0, 5'd7, 1'b1, 1'b1);
    wait_valid("pre_rst_done");
    reset_n = 1'b0;
    #1 check_reset_outputs("rst_done");
    @(posedge clock); #1 reset_n = 1'b1;
    run_op("after_rst", 32'h1234_5678, 5'd12, 1'b1, 1'b0, 32'h0001_2345);

    // Random traffic with response backpressure.
    for (int i = 0; i < 3000; i++) begin
      issue($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      cyc = 0;
      do begin
        rsp_ready = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        cyc++;
      end while (busy && cyc < 200);
      check_eq("rand_done", {31'd0, busy}, 32'd0);
    end
    rsp_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1 check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
